register_pipe_asr: RTL and testbench

REGISTER_PIPE_ASR -- requirements
Module: register_pipe_asr

---
 rtl/register_pipe_asr.sv | 84 ++++++++
 tb/tb_register_pipe_asr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/register_pipe_asr.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, flush, enable freeze and async clear.
// Latency DEPTH-1 edges from accept to q; full throughput; in_ready is combinational from out_ready.
module register_pipe_asr #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 d,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 q,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [N-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;

    logic             w_act;
    logic [DEPTH-1:0] w_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_act      = en && !flush && !clr;
    assign out_valid  = w_act && r_valid[DEPTH-1];
    assign w_out_xfer = out_valid && out_ready;
    assign in_ready   = w_act && (!r_valid[0] || w_adv[0]);
    assign w_in_xfer  = in_valid && in_ready;
    assign q          = r_data[DEPTH-1];
    assign count      = r_count;

    // Walk from the output side so each stage knows whether its successor frees up this cycle.
    always_comb begin
        logic v_go;
        w_adv          = '0;
        v_go           = w_out_xfer;
        w_adv[DEPTH-1] = v_go;
        for (int i = DEPTH-2; i >= 0; i--) begin
            v_go     = w_act && r_valid[i] && (!r_valid[i+1] || v_go);
            w_adv[i] = v_go;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (en && flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_in_xfer) begin
                r_data[0]  <= d;
                r_valid[0] <= 1'b1;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_data[i]  <= r_data[i-1];
                    r_valid[i] <= 1'b1;
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_in_xfer && !w_out_xfer) begin
                r_count <= r_count + CW'(1);
            end else if (w_out_xfer && !w_in_xfer) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_register_pipe_asr.sv
// Directed bench for register_pipe_asr (N=8, DEPTH=4): per-cycle vector table plus corner sequences.
module tb_register_pipe_asr;

    logic       clk = 1'b0;
    logic       clr, en, flush, in_valid, out_ready;
    logic [7:0] d;
    logic       in_ready, out_valid;
    logic [7:0] q;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    register_pipe_asr #(.N(8), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_q;
        logic [2:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic iv, logic ordy, logic [7:0] dd,
                                logic ir, logic ov, logic [7:0] qq, logic [2:0] c);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.d = dd;
        v.e_ir = ir; v.e_ov = ov; v.e_q = qq; v.e_cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic e, input logic f, input logic iv, input logic o, input logic [7:0] dd);
        en = e; flush = f; in_valid = iv; out_ready = o; d = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // streaming 0x11,0x22,0x33 with out_ready=1
        vecs.push_back(mk(1, 1, 8'h11, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h22, 1, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h33, 1, 0, 8'h00, 2));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 8'h00, 3));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'h11, 3));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'h22, 2));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'h33, 1));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 8'h33, 0));
        // fill to full under backpressure, then drain with one concurrent accept
        vecs.push_back(mk(1, 0, 8'hA0, 1, 0, 8'h33, 0));
        vecs.push_back(mk(1, 0, 8'hA1, 1, 0, 8'h33, 1));
        vecs.push_back(mk(1, 0, 8'hA2, 1, 0, 8'h33, 2));
        vecs.push_back(mk(1, 0, 8'hA3, 1, 0, 8'h33, 3));
        vecs.push_back(mk(1, 0, 8'hA4, 0, 1, 8'hA0, 4));
        vecs.push_back(mk(1, 1, 8'hA4, 1, 1, 8'hA0, 4));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'hA1, 4));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'hA2, 3));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'hA3, 2));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'hA4, 1));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 8'hA4, 0));

        clr = 1'b1;
        drive(1, 0, 1, 1, 8'h5A);
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 8'h00);
        chk("rst_count", count, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1, 0, vecs[i].iv, vecs[i].ordy, vecs[i].d);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_q", i), q, vecs[i].e_q);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            tick();
        end

        // enable freeze with two items parked at the output end
        drive(1, 0, 1, 0, 8'hB1); tick();
        drive(1, 0, 1, 0, 8'hB2); tick();
        drive(1, 0, 0, 0, 8'h00); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 8'hCC);
            #1;
            chk("frz_in_ready", in_ready, 0);
            chk("frz_out_valid", out_valid, 0);
            chk("frz_count", count, 2);
            chk("frz_q", q, 8'hB1);
            tick();
        end
        drive(1, 0, 0, 1, 8'h00);
        #1;
        chk("frz_resume_ov", out_valid, 1);
        chk("frz_resume_q0", q, 8'hB1);
        tick();
        chk("frz_resume_q1", q, 8'hB2);
        chk("frz_resume_ov1", out_valid, 1);
        tick();
        chk("frz_drained", count, 0);

        // flush with a competing input
        drive(1, 0, 1, 0, 8'hC1); tick();
        drive(1, 0, 1, 0, 8'hC2); tick();
        drive(1, 0, 1, 0, 8'hC3); tick();
        chk("fl_pre_count", count, 3);
        drive(1, 1, 1, 1, 8'h55);
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid", out_valid, 0);
        tick();
        drive(1, 0, 0, 1, 8'h00);
        #1;
        chk("fl_count", count, 0);
        for (int i = 0; i < 6; i++) begin
            chk("fl_no_out", out_valid, 0);
            chk("fl_no_55", q == 8'h55, 0);
            tick();
        end

        // bubble collapse: item, gap, item under backpressure
        drive(1, 0, 1, 0, 8'h01); tick();
        drive(1, 0, 0, 0, 8'h00); tick();
        drive(1, 0, 1, 0, 8'h02); tick();
        drive(1, 0, 0, 0, 8'h00); tick(); tick(); tick();
        chk("bub_count", count, 2);
        chk("bub_q", q, 8'h01);
        chk("bub_ov", out_valid, 1);
        chk("bub_in_ready", in_ready, 1);
        drive(1, 0, 0, 1, 8'h00);
        #1;
        chk("bub_out0", q, 8'h01);
        tick();
        chk("bub_out1", q, 8'h02);
        chk("bub_out1_ov", out_valid, 1);
        tick();
        chk("bub_empty", count, 0);

        // asynchronous clear during traffic
        drive(1, 0, 1, 1, 8'h77); tick(); tick();
        chk("clr_pre_count", count, 2);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_q", q, 8'h00);
        chk("clr_count", count, 0);
        chk("clr_ov", out_valid, 0);
        chk("clr_in_ready", in_ready, 0);
        tick();
        chk("clr_held_count", count, 0);
        clr = 1'b0;
        #1;
        chk("clr_rel_in_ready", in_ready, 1);
        tick();
        chk("clr_accept_count", count, 1);
        drive(1, 0, 0, 0, 8'h00);
        tick(); tick(); tick();
        chk("clr_after_q", q, 8'h77);
        chk("clr_after_ov", out_valid, 1);
        chk("clr_after_count", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
